pcie_rb_ctrl: RTL and testbench
===============================

Name: pcie_rb_ctrl

Overview:
- Owns the PCIe PDU ring buffer shared by the PDU generator (producer) and the host DMA path (consumer).
- Tracks the write head and the host-reported read tail, and supplies the producer's base address and almost-full backpressure.
- Sequences head-pointer doorbells to the DMA engine, coalescing updates, and keeps error/statistics state for the host CSR block.

Parameters:
PDU_AWIDTH, 12, ring address width; depth DEPTH = 2^PDU_AWIDTH flits.
AF_MARGIN, 64, minimum free flits required to keep almost_full low; covers the largest PDU (header + payload + rule flits).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pcie_rb_update_valid  in  1  producer committed one PDU (one-cycle pulse)
pcie_rb_update_size  in  PDU_AWIDTH  flits in committed PDU, header included
pcie_rb_wr_base_addr  out  PDU_AWIDTH  slot for the next PDU header
pcie_rb_almost_full  out  1  free space < AF_MARGIN
host_tail_valid  in  1  host CSR write of read tail
host_tail  in  PDU_AWIDTH+1  new tail, MSB is the wrap bit
host_flush  in  1  pulse: empty the ring
dma_head_valid  out  1  doorbell request
dma_head  out  PDU_AWIDTH+1  head value carried by the doorbell
dma_head_ready  in  1  DMA engine accepts doorbell
rb_occupancy  out  PDU_AWIDTH+1  used flits
pdu_cnt  out  32  committed PDUs since reset/flush
overflow_err  out  1  sticky: a commit exceeded free space
tail_err  out  1  sticky: illegal tail write rejected

Behaviour:
- Reset values: head=0, tail=0, pcie_rb_wr_base_addr=0, pcie_rb_almost_full=1 for the reset cycle then recomputed, dma_head_valid=0, dma_head=0, rb_occupancy=0, pdu_cnt=0, both error flags=0, FSM=IDLE.
- Pointers are PDU_AWIDTH+1 bits. Addresses wrap modulo DEPTH with no contiguity padding, because the producer's address increment wraps naturally.
- Occupancy and free space:
  - occ = head - tail, computed mod 2^(PDU_AWIDTH+1).
  - free = DEPTH - occ.
  - A full ring (occ = DEPTH) is legal.
- Commit, when update_valid=1:
  - head <= head + update_size.
  - pdu_cnt <= pdu_cnt + 1, wrapping at 2^32.
  - If update_size > free in that cycle, set overflow_err; head still advances because the data is already written.
  - update_size = 0 is ignored: no head change, no count.
- pcie_rb_wr_base_addr = head[PDU_AWIDTH-1:0], registered. It reflects a commit on the cycle after update_valid.
- pcie_rb_almost_full and rb_occupancy are registered and computed from post-update pointers. Latency is 1 cycle after a commit or tail write.
- Host tail write:
  - Accepted only if the new occ = head - host_tail satisfies occ <= DEPTH and the value does not move the tail backwards, i.e. (host_tail - tail) <= (head - tail).
  - Otherwise the write is ignored and tail_err is set.
- Flush (host_flush=1):
  - head <= 0, tail <= 0, pdu_cnt <= 0, errors cleared, FSM -> IDLE, dma_head_valid <= 0.
  - Any update_valid or host_tail_valid in the same cycle is discarded.
- Same-cycle commit and tail write: both are applied. Occupancy uses the new head and the new tail. Legality of the tail is checked against the pre-commit head.
- Doorbell FSM:
  - IDLE:
    - If head != last_sent, load dma_head <= head, set dma_head_valid=1 and go to NOTIFY.
    - last_sent resets to 0.
  - NOTIFY:
    - Hold dma_head_valid and dma_head stable until dma_head_ready.
    - On the handshake: last_sent <= dma_head, dma_head_valid <= 0, go to IDLE.
  - Coalescing:
    - Commits during NOTIFY do not change dma_head.
    - IDLE picks up the newest head on the next cycle, so at most one doorbell is outstanding.
    - Minimum doorbell spacing is 2 cycles.
  - valid/ready is AXI-style: valid never drops without ready, except on rst or flush.
- Reset mid-operation: all state returns to reset values on the next edge. No doorbell is issued for pre-reset commits.

Test Plan:
1. Reset then idle -> wr_base_addr=0, occupancy=0, almost_full=0 on cycle 2, dma_head_valid=0.
2. Commit sizes 5 then 3, one per 2 cycles, dma_head_ready=1 -> base_addr 5 then 8; doorbells carry 5 then 8; pdu_cnt=2.
3. Hold dma_head_ready=0, then commit sizes 4, 4, 4 -> first doorbell dma_head=4 stays stable. After ready is pulsed, a single second doorbell carries 12; 2 doorbells total.
4. Commit total 4040 flits with DEPTH=4096 -> almost_full=1 (free 56 < 64). Host tail=100 -> almost_full=0 the next cycle.
5. head=4090, commit 10 -> base_addr=4 and head=4100 (wrap bit set). Then host tail=4100 -> occupancy=0.
6. Host tail ahead of head (head=20, tail write 30) -> ignored, tail_err=1. Then host_flush with a simultaneous update_valid -> head=0, pdu_cnt=0, errors cleared, no doorbell.

Source files
------------

// File: rtl/pcie_rb_ctrl.sv
// PCIe PDU ring-buffer controller: head/tail tracking, producer backpressure,
// coalesced head doorbells to the DMA engine and host-visible error/statistics state.
module pcie_rb_ctrl #(
  parameter int PDU_AWIDTH = 12,
  parameter int AF_MARGIN  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pcie_rb_update_valid,
  input  logic [PDU_AWIDTH-1:0] pcie_rb_update_size,
  output logic [PDU_AWIDTH-1:0] pcie_rb_wr_base_addr,
  output logic                  pcie_rb_almost_full,
  input  logic                  host_tail_valid,
  input  logic [PDU_AWIDTH:0]   host_tail,
  input  logic                  host_flush,
  output logic                  dma_head_valid,
  output logic [PDU_AWIDTH:0]   dma_head,
  input  logic                  dma_head_ready,
  output logic [PDU_AWIDTH:0]   rb_occupancy,
  output logic [31:0]           pdu_cnt,
  output logic                  overflow_err,
  output logic                  tail_err
);

  localparam int PW = PDU_AWIDTH + 1;
  localparam int FW = PDU_AWIDTH + 3;
  localparam logic [PW-1:0]        DEPTH_P = {1'b1, {PDU_AWIDTH{1'b0}}};
  localparam logic signed [FW-1:0] AF_S    = FW'(AF_MARGIN);

  typedef enum logic {IDLE, NOTIFY} db_state_t;

  db_state_t     state, state_next;
  logic [PW-1:0] head, tail, last_sent;
  logic [PW-1:0] head_next, tail_next, occ_cur, occ_tail, tail_adv, occ_next;
  logic          commit, tail_ok, overflow_hit, db_load, db_done;

  // Free space is signed: after an overflow occ can exceed DEPTH and free goes negative.
  function automatic logic signed [FW-1:0] free_of(input logic [PW-1:0] occ);
    return signed'({2'b00, DEPTH_P}) - signed'({2'b00, occ});
  endfunction

  always_comb begin
    commit       = pcie_rb_update_valid && (pcie_rb_update_size != '0);
    occ_cur      = head - tail;
    occ_tail     = head - host_tail;
    tail_adv     = host_tail - tail;
    tail_ok      = (occ_tail <= DEPTH_P) && (tail_adv <= occ_cur);
    overflow_hit = commit && (signed'({3'b000, pcie_rb_update_size}) > free_of(occ_cur));
    head_next    = commit ? head + {1'b0, pcie_rb_update_size} : head;
    tail_next    = (host_tail_valid && tail_ok) ? host_tail : tail;
    if (host_flush) begin
      head_next = '0;
      tail_next = '0;
    end
    occ_next = head_next - tail_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head                <= '0;
      tail                <= '0;
      rb_occupancy        <= '0;
      pcie_rb_almost_full <= 1'b1;
      pdu_cnt             <= '0;
      overflow_err        <= 1'b0;
      tail_err            <= 1'b0;
    end else begin
      head                <= head_next;
      tail                <= tail_next;
      rb_occupancy        <= occ_next;
      pcie_rb_almost_full <= free_of(occ_next) < AF_S;
      if (host_flush) begin
        pdu_cnt      <= '0;
        overflow_err <= 1'b0;
        tail_err     <= 1'b0;
      end else begin
        if (commit)                       pdu_cnt      <= pdu_cnt + 32'd1;
        if (overflow_hit)                 overflow_err <= 1'b1;
        if (host_tail_valid && !tail_ok)  tail_err     <= 1'b1;
      end
    end
  end

  assign pcie_rb_wr_base_addr = head[PDU_AWIDTH-1:0];

  // Doorbell FSM: at most one outstanding; IDLE picks up the newest head.
  always_ff @(posedge clk) begin
    if (rst || host_flush) state <= IDLE;
    else                   state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (head != last_sent) state_next = NOTIFY;
      NOTIFY:  if (dma_head_ready)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dma_head_valid = (state == NOTIFY);
    db_load        = (state == IDLE) && (head != last_sent);
    db_done        = (state == NOTIFY) && dma_head_ready;
  end

  always_ff @(posedge clk) begin
    if (rst || host_flush) begin
      dma_head  <= '0;
      last_sent <= '0;
    end else if (db_load) begin
      dma_head <= head;
    end else if (db_done) begin
      last_sent <= dma_head;
    end
  end

endmodule

// File: tb/tb_pcie_rb_ctrl.sv
// Directed bench for pcie_rb_ctrl: ring arithmetic model checked every cycle plus
// hand-computed expectations for each scenario.
module tb_pcie_rb_ctrl;
  localparam int AW = 12;
  localparam int AF = 64;
  localparam int D  = 1 << AW;
  localparam int M2 = 2 * D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pcie_rb_update_valid = 1'b0;
  logic [AW-1:0] pcie_rb_update_size = '0;
  logic [AW-1:0] pcie_rb_wr_base_addr;
  logic          pcie_rb_almost_full;
  logic          host_tail_valid = 1'b0;
  logic [AW:0]   host_tail = '0;
  logic          host_flush = 1'b0;
  logic          dma_head_valid;
  logic [AW:0]   dma_head;
  logic          dma_head_ready = 1'b1;
  logic [AW:0]   rb_occupancy;
  logic [31:0]   pdu_cnt;
  logic          overflow_err;
  logic          tail_err;

  pcie_rb_ctrl #(.PDU_AWIDTH(AW), .AF_MARGIN(AF)) dut (
    .clk(clk), .rst(rst),
    .pcie_rb_update_valid(pcie_rb_update_valid),
    .pcie_rb_update_size(pcie_rb_update_size),
    .pcie_rb_wr_base_addr(pcie_rb_wr_base_addr),
    .pcie_rb_almost_full(pcie_rb_almost_full),
    .host_tail_valid(host_tail_valid), .host_tail(host_tail),
    .host_flush(host_flush),
    .dma_head_valid(dma_head_valid), .dma_head(dma_head),
    .dma_head_ready(dma_head_ready),
    .rb_occupancy(rb_occupancy), .pdu_cnt(pdu_cnt),
    .overflow_err(overflow_err), .tail_err(tail_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [AW:0] db_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wrap(input int x);
    return ((x % M2) + M2) % M2;
  endfunction

  // Ring model: pointers as plain integers modulo 2*DEPTH.
  int   m_head, m_tail, m_occ, occ_v, nh, nt;
  bit   m_af, m_ovf, m_terr, m_kill_db, m_rst_db, started;
  bit [31:0] m_cnt;

  always @(posedge clk) begin
    started   = 1'b1;
    m_kill_db = rst || host_flush;
    m_rst_db  = rst;
    if (rst || host_flush) begin
      m_head = 0; m_tail = 0; m_cnt = 0; m_ovf = 0; m_terr = 0;
    end else begin
      occ_v = wrap(m_head - m_tail);
      nh = m_head;
      nt = m_tail;
      if (pcie_rb_update_valid && pcie_rb_update_size != 0) begin
        if (int'(pcie_rb_update_size) > D - occ_v) m_ovf = 1'b1;
        nh = wrap(m_head + int'(pcie_rb_update_size));
        m_cnt = m_cnt + 1;
      end
      if (host_tail_valid) begin
        if (wrap(m_head - int'(host_tail)) <= D && wrap(int'(host_tail) - m_tail) <= occ_v)
          nt = int'(host_tail);
        else
          m_terr = 1'b1;
      end
      m_head = nh;
      m_tail = nt;
    end
    m_occ = wrap(m_head - m_tail);
    m_af  = rst ? 1'b1 : ((D - m_occ) < AF);
  end

  logic        pv, pr, pk;
  logic [AW:0] ph;
  initial begin pv = 1'b0; pr = 1'b0; pk = 1'b1; ph = '0; end

  always @(negedge clk) begin
    if (started) begin
      chk("base_addr", pcie_rb_wr_base_addr, m_head % D);
      chk("occupancy", rb_occupancy, m_occ);
      chk("almost_full", pcie_rb_almost_full, m_af);
      chk("pdu_cnt", pdu_cnt, m_cnt);
      chk("overflow_err", overflow_err, m_ovf);
      chk("tail_err", tail_err, m_terr);
      if (m_kill_db) chk("db_valid_killed", dma_head_valid, 0);
      if (m_rst_db)  chk("db_head_reset", dma_head, 0);
      if (pv && !pr && !pk) begin
        chk("db_valid_held", dma_head_valid, 1);
        chk("db_head_stable", dma_head, ph);
      end
      if (dma_head_valid && dma_head_ready && !rst && !host_flush) db_q.push_back(dma_head);
      pv = dma_head_valid;
      pr = dma_head_ready;
      ph = dma_head;
      pk = rst || host_flush;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic commit(input int sz);
    pcie_rb_update_valid = 1'b1;
    pcie_rb_update_size  = AW'(sz);
    tick();
    pcie_rb_update_valid = 1'b0;
    pcie_rb_update_size  = '0;
  endtask

  task automatic write_tail(input int t);
    host_tail_valid = 1'b1;
    host_tail       = (AW+1)'(t);
    tick();
    host_tail_valid = 1'b0;
  endtask

  task automatic flush();
    host_flush = 1'b1;
    tick();
    host_flush = 1'b0;
    db_q.delete();
  endtask

  task automatic chk_last_db(input string name, input int exp);
    if (db_q.size() == 0) chk(name, 64'hFFFF, exp);
    else                  chk(name, db_q[db_q.size()-1], exp);
  endtask

  initial begin
    // 1: reset then idle
    tick(2);
    chk("t1_af_in_reset", pcie_rb_almost_full, 1);
    chk("t1_db_valid_reset", dma_head_valid, 0);
    rst = 1'b0;
    tick();
    chk("t1_af_cycle2", pcie_rb_almost_full, 0);
    chk("t1_base", pcie_rb_wr_base_addr, 0);
    chk("t1_occ", rb_occupancy, 0);

    // 2: commits 5 then 3, ready held high
    commit(5);
    chk("t2_base_5", pcie_rb_wr_base_addr, 5);
    tick();
    commit(3);
    chk("t2_base_8", pcie_rb_wr_base_addr, 8);
    tick(6);
    chk("t2_pdu_cnt", pdu_cnt, 2);
    chk("t2_db_count", db_q.size(), 2);
    if (db_q.size() == 2) begin
      chk("t2_db0", db_q[0], 5);
      chk("t2_db1", db_q[1], 8);
    end
    chk("t2_db_idle", dma_head_valid, 0);

    // 3: coalescing while the DMA engine stalls
    flush();
    dma_head_ready = 1'b0;
    commit(4); commit(4); commit(4);
    tick(3);
    chk("t3_db_pending", dma_head_valid, 1);
    chk("t3_db_head_4", dma_head, 4);
    chk("t3_no_handshake", db_q.size(), 0);
    dma_head_ready = 1'b1;
    tick();
    dma_head_ready = 1'b0;
    tick(2);
    chk("t3_db2_pending", dma_head_valid, 1);
    chk("t3_db_head_12", dma_head, 12);
    dma_head_ready = 1'b1;
    tick(4);
    chk("t3_db_total", db_q.size(), 2);
    chk_last_db("t3_db_last", 12);

    // 4: almost_full threshold and release by tail write
    flush();
    commit(1000); commit(1000); commit(1000); commit(1000); commit(40);
    chk("t4_occ_4040", rb_occupancy, 4040);
    chk("t4_af_set", pcie_rb_almost_full, 1);
    write_tail(100);
    chk("t4_af_clear", pcie_rb_almost_full, 0);
    chk("t4_occ_3940", rb_occupancy, 3940);
    tick(4);
    chk_last_db("t4_db_last", 4040);

    // 5: wrap of the address and the pointer wrap bit
    flush();
    commit(4090);
    write_tail(4090);
    chk("t5_occ_0", rb_occupancy, 0);
    commit(10);
    chk("t5_base_wrap", pcie_rb_wr_base_addr, 4);
    chk("t5_occ_10", rb_occupancy, 10);
    chk("t5_no_ovf", overflow_err, 0);
    write_tail(4100);
    chk("t5_occ_after_tail", rb_occupancy, 0);
    tick(4);
    chk_last_db("t5_db_wrapbit", 4100);

    // overflow: commit larger than remaining free space
    flush();
    commit(4095);
    chk("ovf_af_full", pcie_rb_almost_full, 1);
    commit(2);
    chk("ovf_flag", overflow_err, 1);
    chk("ovf_occ", rb_occupancy, 4097);

    // 6: illegal tail, then flush racing a commit
    flush();
    commit(20);
    tick(4);
    write_tail(30);
    chk("t6_tail_err", tail_err, 1);
    chk("t6_occ_kept", rb_occupancy, 20);
    db_q.delete();
    host_flush = 1'b1;
    pcie_rb_update_valid = 1'b1;
    pcie_rb_update_size  = 7;
    tick();
    host_flush = 1'b0;
    pcie_rb_update_valid = 1'b0;
    pcie_rb_update_size  = '0;
    chk("t6_base_0", pcie_rb_wr_base_addr, 0);
    chk("t6_cnt_0", pdu_cnt, 0);
    chk("t6_terr_clr", tail_err, 0);
    tick(5);
    chk("t6_no_doorbell", db_q.size(), 0);
    chk("t6_db_idle", dma_head_valid, 0);

    // reset mid-operation drops the pending doorbell
    commit(9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    db_q.delete();
    tick(5);
    chk("rst_no_doorbell", db_q.size(), 0);
    chk("rst_cnt_0", pdu_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
